fifo_rr_write_arbiter: RTL and testbench

Shares the single write port of an 8-bit synchronous FIFO among NUM_REQ producers using round-robin arbitration with burst locking. Keeps its own credit-based occupancy count from its writes and the FIFO's reads, so it never depends on the FIFO's lagging registered full flag. It sits directly in front of the FIFO: it drives wr_en/data_in and observes rd_en/empty.

---
 rtl/fifo_rr_write_arbiter.sv | 169 ++++++++++++++++
 tb/tb_fifo_rr_write_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin write-port arbiter with burst locking and credit-based occupancy tracking.
// Optional macro ARB_TIMEOUT_EN adds an idle-grant timeout with a timeout_err pulse.
module fifo_rr_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 8,
  parameter int TIMEOUT    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_rd_en,
  input  logic                          fifo_empty,
  output logic                          fifo_wr_en,
  output logic [DATA_W-1:0]             fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  localparam int          GW = $clog2(NUM_REQ);
  localparam int          OW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned NR = NUM_REQ;

  typedef enum logic {IDLE, BURST} state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [7:0]          beat_q, beat_d;
  logic [OW-1:0]       occ_q, occ_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic                credit, xfer, inc, dec, last_beat;
  logic                g_last;
  logic [DATA_W-1:0]   g_data;
  logic [NUM_REQ-1:0]  ready;
  logic [GW-1:0]       pick;
  logic                pick_vld;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q, idle_d;
  logic          tout_q, tout_d;
`endif

  // Round-robin search starts one past the last grant, so the last winner is checked last.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned off = 1; off <= NR; off++) begin
      if (!pick_vld && req_valid[GW'((32'(grant_q) + off) % NR)]) begin
        pick     = GW'((32'(grant_q) + off) % NR);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    credit = (occ_q < OW'(FIFO_DEPTH));
    ready  = '0;
    g_data = '0;
    g_last = 1'b0;
    for (int unsigned i = 0; i < NR; i++) begin
      ready[i] = (state_q == BURST) && (grant_q == GW'(i)) && credit;
      if (grant_q == GW'(i)) begin
        g_data = req_data[i*DATA_W +: DATA_W];
        g_last = req_last[i];
      end
    end
    xfer      = |(req_valid & ready);
    last_beat = (({1'b0, beat_q} + 9'd1) == 9'(MAX_BURST));
    inc       = xfer;
    dec       = fifo_rd_en && !fifo_empty && (occ_q != '0);
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    beat_d    = beat_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    occ_d     = occ_q;
`ifdef ARB_TIMEOUT_EN
    idle_d    = '0;
    tout_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
`ifdef ARB_TIMEOUT_EN
        idle_d = idle_q;
`endif
        if (xfer) begin
          wr_en_d   = 1'b1;
          wr_data_d = g_data;
          beat_d    = beat_q + 8'd1;
          if (g_last || last_beat) state_d = IDLE;
`ifdef ARB_TIMEOUT_EN
          idle_d = '0;
        end else if (credit) begin
          // Stalls caused by a full FIFO are not the requester's fault and do not count.
          if (({1'b0, idle_q} + (TW+1)'(1)) == (TW+1)'(TIMEOUT)) begin
            state_d = IDLE;
            idle_d  = '0;
            tout_d  = 1'b1;
          end else begin
            idle_d = idle_q + TW'(1);
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (inc && !dec)      occ_d = occ_q + OW'(1);
    else if (dec && !inc) occ_d = occ_q - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= GW'(NUM_REQ - 1);
      beat_q    <= '0;
      occ_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
`ifdef ARB_TIMEOUT_EN
      idle_q    <= '0;
      tout_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      beat_q    <= beat_d;
      occ_q     <= occ_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
`ifdef ARB_TIMEOUT_EN
      idle_q    <= idle_d;
      tout_q    <= tout_d;
`endif
    end
  end

  assign req_ready    = ready;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q == BURST);
  assign occupancy    = occ_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout_err  = tout_q;
`endif

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Directed bench for fifo_rr_write_arbiter: reset, round-robin order, burst cut, credit limit,
// simultaneous read/write, reset mid-burst (and the timeout when ARB_TIMEOUT_EN is defined).
module tb_fifo_rr_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        fifo_rd_en, fifo_empty, fifo_wr_en, busy;
  logic [7:0]  fifo_wr_data;
  logic [1:0]  grant_id;
  logic [4:0]  occupancy;
`ifdef ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fifo_rr_write_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .FIFO_DEPTH(16), .MAX_BURST(8), .TIMEOUT(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .grant_id(grant_id), .busy(busy), .occupancy(occupancy)
`ifdef ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    fifo_rd_en = 1'b0; fifo_empty = 1'b0;
    step(); step();
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant_id), 3);
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    check("rst_wr_data", 32'(fifo_wr_data), 0);
    check("rst_occ", 32'(occupancy), 0);
    check("rst_ready", 32'(req_ready), 0);

    // Single requester 2, three beats.
    rst_n = 1'b1; req_valid = 4'b0100; req_data[23:16] = 8'hA1;
    step();
    check("t1_grant", 32'(grant_id), 2);
    check("t1_busy", 32'(busy), 1);
    check("t1_ready", 32'(req_ready), 32'h4);
    check("t1_arb_no_wr", 32'(fifo_wr_en), 0);
    step();
    check("t1_wr1", 32'(fifo_wr_en), 1);
    check("t1_d1", 32'(fifo_wr_data), 32'hA1);
    check("t1_occ1", 32'(occupancy), 1);
    req_data[23:16] = 8'hA2;
    step();
    check("t1_d2", 32'(fifo_wr_data), 32'hA2);
    check("t1_occ2", 32'(occupancy), 2);
    req_data[23:16] = 8'hA3; req_last = 4'b0100;
    step();
    check("t1_wr3", 32'(fifo_wr_en), 1);
    check("t1_d3", 32'(fifo_wr_data), 32'hA3);
    check("t1_occ3", 32'(occupancy), 3);
    check("t1_rel_busy", 32'(busy), 0);
    check("t1_rel_grant", 32'(grant_id), 2);
    check("t1_rel_ready", 32'(req_ready), 0);
    req_valid = '0; req_last = '0;
    step();
    check("t1_idle_wr", 32'(fifo_wr_en), 0);
    check("t1_hold_data", 32'(fifo_wr_data), 32'hA3);

    // Round robin, all valid, 2-beat bursts: order 0,1,2,3,0.
    rst_n = 1'b0; step(); rst_n = 1'b1; req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      step();
      check("rr_grant", 32'(grant_id), 32'(g));
      check("rr_ready", 32'(req_ready), 32'(1 << g));
      check("rr_gap", 32'(fifo_wr_en), 0);
      req_data[g*8 +: 8] = 8'(16*g + 2*k + 1); req_last = '0;
      step();
      check("rr_b1", 32'(fifo_wr_data), 32'(16*g + 2*k + 1));
      req_data[g*8 +: 8] = 8'(16*g + 2*k + 2); req_last[g] = 1'b1;
      step();
      check("rr_b2_wr", 32'(fifo_wr_en), 1);
      check("rr_b2", 32'(fifo_wr_data), 32'(16*g + 2*k + 2));
      check("rr_rel", 32'(busy), 0);
      req_last = '0;
    end
    check("rr_occ", 32'(occupancy), 10);
    req_valid = '0;

    // MAX_BURST cut on requester 1, then 3 gets its turn before 1 resumes.
    rst_n = 1'b0; step(); rst_n = 1'b1; req_valid = 4'b0010;
    step();
    check("mb_grant", 32'(grant_id), 1);
    for (int b = 0; b < 8; b++) begin
      req_data[15:8] = 8'(8'h30 + b);
      step();
      check("mb_wr", 32'(fifo_wr_en), 1);
      check("mb_data", 32'(fifo_wr_data), 32'(8'h30 + b));
      check("mb_busy", 32'(busy), (b < 7) ? 1 : 0);
    end
    check("mb_occ8", 32'(occupancy), 8);
    req_valid = 4'b1010; req_data[31:24] = 8'hC3; req_last = 4'b1000; req_data[15:8] = 8'h38;
    step();
    check("mb_other_grant", 32'(grant_id), 3);
    step();
    check("mb_other_data", 32'(fifo_wr_data), 32'hC3);
    check("mb_other_rel", 32'(busy), 0);
    req_last = '0;
    step();
    check("mb_resume_grant", 32'(grant_id), 1);
    step();
    check("mb_b9", 32'(fifo_wr_data), 32'h38);
    req_data[15:8] = 8'h39; req_last = 4'b0010;
    step();
    check("mb_b10", 32'(fifo_wr_data), 32'h39);
    check("mb_occ11", 32'(occupancy), 11);
    req_valid = '0; req_last = '0;

    // Credit limit: 16 writes, no reads.
    rst_n = 1'b0; step(); rst_n = 1'b1; req_valid = 4'b0001;
    for (int burst = 0; burst < 2; burst++) begin
      step();
      check("fl_grant_busy", 32'(busy), 1);
      for (int b = 0; b < 8; b++) begin
        req_data[7:0] = 8'(16*burst + b);
        step();
        check("fl_data", 32'(fifo_wr_data), 32'(16*burst + b));
      end
    end
    check("fl_occ16", 32'(occupancy), 16);
    step();
    check("fl_regrant", 32'(busy), 1);
    check("fl_ready0", 32'(req_ready), 0);
    step();
    check("fl_no_wr", 32'(fifo_wr_en), 0);
    check("fl_still16", 32'(occupancy), 16);
    fifo_rd_en = 1'b1;
    step();
    check("fl_occ15", 32'(occupancy), 15);
    check("fl_ready_back", 32'(req_ready), 32'h1);
    fifo_rd_en = 1'b0;
    step();
    check("fl_wr17th", 32'(fifo_wr_en), 1);
    check("fl_data17th", 32'(fifo_wr_data), 32'h17);
    check("fl_occ_back16", 32'(occupancy), 16);
    check("fl_ready_off", 32'(req_ready), 0);
    fifo_rd_en = 1'b1; fifo_empty = 1'b1;
    step();
    check("fl_empty_no_dec", 32'(occupancy), 16);
    fifo_rd_en = 1'b0; fifo_empty = 1'b0;

    // Underflow guard, then simultaneous read/write at occupancy 5.
    req_valid = '0; rst_n = 1'b0; step(); rst_n = 1'b1;
    fifo_rd_en = 1'b1;
    step();
    check("uf_occ0", 32'(occupancy), 0);
    fifo_rd_en = 1'b0; req_valid = 4'b0001;
    step();
    check("rw_grant", 32'(grant_id), 0);
    for (int b = 0; b < 5; b++) begin
      req_data[7:0] = 8'(8'h50 + b);
      step();
      check("rw_occ", 32'(occupancy), 32'(b + 1));
    end
    req_data[7:0] = 8'h55; req_last = 4'b0001; fifo_rd_en = 1'b1;
    step();
    check("rw_data", 32'(fifo_wr_data), 32'h55);
    check("rw_occ5", 32'(occupancy), 5);
    check("rw_rel", 32'(busy), 0);
    fifo_rd_en = 1'b0; req_last = '0;

    // Reset mid-burst.
    req_valid = 4'b0101; req_data[23:16] = 8'h60;
    step();
    check("mr_grant", 32'(grant_id), 2);
    step();
    check("mr_wr", 32'(fifo_wr_data), 32'h60);
    check("mr_occ6", 32'(occupancy), 6);
    req_data[23:16] = 8'h61; rst_n = 1'b0;
    step();
    check("mr_busy", 32'(busy), 0);
    check("mr_wr_en", 32'(fifo_wr_en), 0);
    check("mr_occ", 32'(occupancy), 0);
    check("mr_grant_rst", 32'(grant_id), 3);
    rst_n = 1'b1;
    step();
    check("mr_restart", 32'(grant_id), 0);
    check("mr_restart_busy", 32'(busy), 1);
    check("mr_no_wr", 32'(fifo_wr_en), 0);

`ifdef ARB_TIMEOUT_EN
    req_valid = '0; rst_n = 1'b0; step(); rst_n = 1'b1; req_valid = 4'b0001;
    step();
    check("to_grant", 32'(grant_id), 0);
    req_valid = 4'b0010;
    for (int c = 0; c < 31; c++) begin
      step();
      check("to_hold", 32'({busy, timeout_err}), 32'h2);
    end
    step();
    check("to_release", 32'(busy), 0);
    check("to_err", 32'(timeout_err), 1);
    step();
    check("to_err_pulse", 32'(timeout_err), 0);
    check("to_next_grant", 32'(grant_id), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
